mul_seq_32x32: RTL and testbench

Multi-cycle 32x32 integer multiply sequencer for the RISC-V M-extension execute stage. It time-multiplexes a single `vedic_16x16` array over four partial-product cycles, accumulates them into a 64-bit sum, applies the sign fix-up, and returns the 32-bit word selected by the opcode. It sits between the execute-stage issue logic and the shared 16x16 multiplier, and replaces four parallel arrays with one.

---
 rtl/mul_defs_pkg.sv | 23 ++
 rtl/vedic_16x16.sv | 23 ++
 rtl/mul_seq_32x32.sv | 122 ++++++++++++
 tb/tb_mul_seq_32x32.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mul_defs_pkg.sv
// Shared op and state encodings for the sequential multiplier and the
// execute-stage decoder.
package mul_defs_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PP   = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // Magnitude of a 32-bit operand; 0x80000000 stays 0x80000000 as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/vedic_16x16.sv
// Combinational 16x16 unsigned multiplier built from four 8x8 sub-products
// (vertical-and-crosswise split).
module vedic_16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [15:0] ll, hl, lh, hh;

    // Four 8x8 partial products recombined with 8-bit-aligned shifts.
    always_comb begin
        ll = {8'd0, a[7:0]}  * {8'd0, b[7:0]};
        hl = {8'd0, a[15:8]} * {8'd0, b[7:0]};
        lh = {8'd0, a[7:0]}  * {8'd0, b[15:8]};
        hh = {8'd0, a[15:8]} * {8'd0, b[15:8]};
        p  = {16'd0, ll}
           + ({16'd0, hl} << 8)
           + ({16'd0, lh} << 8)
           + ({hh, 16'd0});
    end

endmodule

// File: rtl/mul_seq_32x32.sv
// Multi-cycle 32x32 multiplier: one shared 16x16 array, four partial-product
// cycles into a 64-bit accumulator, sign fix-up, word select by opcode.
module mul_seq_32x32
    import mul_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_e      state_q, state_d;
    logic [1:0]  cnt;
    logic [63:0] acc;
    op_e         op_q;
    logic [31:0] a_mag, b_mag;
    logic        neg;

    logic        cap_en, acc_en, fin_en, busy_d;
    logic        a_sgn, b_sgn;
    logic [15:0] ha, hb;
    logic [31:0] pp;
    logic [63:0] pp_sh, acc_sum, prod;

    // Operand signedness depends on the opcode; MUL/MULHU are unsigned.
    always_comb begin
        a_sgn = (op_e'(op) == OP_MULH) || (op_e'(op) == OP_MULHSU);
        b_sgn = (op_e'(op) == OP_MULH);
    end

    // Operand-half mux: pick the 16-bit halves for the current partial product.
    always_comb begin
        ha = a_mag[15:0];
        hb = b_mag[15:0];
        unique case (cnt)
            2'd0: begin ha = a_mag[15:0];  hb = b_mag[15:0];  end
            2'd1: begin ha = a_mag[31:16]; hb = b_mag[15:0];  end
            2'd2: begin ha = a_mag[15:0];  hb = b_mag[31:16]; end
            2'd3: begin ha = a_mag[31:16]; hb = b_mag[31:16]; end
        endcase
    end

    vedic_16x16 u_mul (
        .a (ha),
        .b (hb),
        .p (pp)
    );

    // Align the partial product and add; the true product fits in 64 bits.
    always_comb begin
        pp_sh = {32'd0, pp};
        unique case (cnt)
            2'd0:       pp_sh = {32'd0, pp};
            2'd1, 2'd2: pp_sh = {16'd0, pp, 16'd0};
            2'd3:       pp_sh = {pp, 32'd0};
        endcase
        acc_sum = acc + pp_sh;
        prod    = neg ? (~acc + 64'd1) : acc;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE, so it never queues.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PP;
            S_PP:    if (cnt == 2'd3) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/enable decode from the current state.
    always_comb begin
        cap_en = (state_q == S_IDLE) && start;
        acc_en = (state_q == S_PP);
        fin_en = (state_q == S_FIN);
        busy_d = (state_d != S_IDLE);
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            acc    <= 64'd0;
            op_q   <= OP_MUL;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            busy <= busy_d;
            done <= fin_en;
            if (cap_en) begin
                op_q  <= op_e'(op);
                a_mag <= mag32(rs1, a_sgn);
                b_mag <= mag32(rs2, b_sgn);
                neg   <= (a_sgn & rs1[31]) ^ (b_sgn & rs2[31]);
                acc   <= 64'd0;
                cnt   <= 2'd0;
            end else if (acc_en) begin
                acc <= acc_sum;
                cnt <= cnt + 2'd1;
            end
            if (fin_en)
                result <= (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        end
    end

endmodule

// File: tb/tb_mul_seq_32x32.sv
// Directed and randomized bench for mul_seq_32x32.
module tb_mul_seq_32x32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    mul_seq_32x32 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits by its signedness, multiply mod 2^64.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (o == 2'b01)               ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op, wait (bounded) for done, check latency, result, and idle after.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int n;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd5);
        chk({tag, " result"}, 64'(result), 64'(exp));
        tick();
        chk({tag, " done_low"}, 64'(done), 64'd0);
        chk({tag, " busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_op(2'b00, 32'd3, 32'd5, 32'h0000000F, "mul 3x5");
        run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh min*min");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh -1*-1");
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu max*max");
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu -1*max");
        run_op(2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, "mulh min*1");
        run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mul min*max");

        // Starts while busy are ignored: MULHU 0xFFFFFFFF x 2 -> high word 1
        op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'd2; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();                                   // E1
        op = 2'b00; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
        tick();                                   // E2 (ignored)
        start = 1'b0;
        chk("ignore done e2", 64'(done), 64'd0);
        tick();                                   // E3
        op = 2'b01; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; start = 1'b1;
        tick();                                   // E4 (ignored)
        start = 1'b0;
        chk("ignore done e4", 64'(done), 64'd0);
        tick();                                   // E5
        chk("ignore done e5", 64'(done), 64'd1);
        chk("ignore result", 64'(result), 64'd1);

        // Back-to-back start on the done cycle: 0x20000 x 0x30000 -> high word 6
        op = 2'b11; rs1 = 32'h00020000; rs2 = 32'h00030000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b single done", 64'(done), 64'd0);
        chk("b2b busy", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        chk("b2b latency", 64'(n), 64'd5);
        chk("b2b result", 64'(result), 64'd6);
        tick();

        // Reset mid-PP at cnt=2 discards the op
        op = 2'b00; rs1 = 32'd100; rs2 = 32'd100; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();                                   // E1
        tick();                                   // E2, cnt=2
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n++;
        end
        chk("midrst no done", 64'(n), 64'd0);
        run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul 7x6 after rst");

        // Edge operand cross product for every op
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    run_op(2'(o), edges[i], edges[j], ref_res(2'(o), edges[i], edges[j]), "edge");

        // Randomized ops against the 64-bit reference
        for (int k = 0; k < 2000; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = edges[$urandom_range(0, 4)];
            run_op(ro, ra, rb, ref_res(ro, ra, rb), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
